// File: rtl/fetch_top.sv
// IF stage: owns the PC, fetches over a req/ready memory handshake and registers the IF/ID boundary.
// Optional `FETCH_PERF_EN` adds the perf_fetched / perf_wait event counters.
module fetch_top #(
    parameter int unsigned           ADDR_SIZE  = 32,
    parameter int unsigned           INSTR_SIZE = 32,
    parameter logic [ADDR_SIZE-1:0]  BOOT_ADDR  = 32'h0000_1000,
    parameter logic [INSTR_SIZE-1:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_SIZE-1:0]  branch_target,
    output logic                  imem_req,
    output logic [ADDR_SIZE-1:0]  imem_addr,
    input  logic                  imem_ready,
    input  logic [INSTR_SIZE-1:0] imem_data,
    output logic [ADDR_SIZE-1:0]  out_pc,
    output logic [INSTR_SIZE-1:0] out_instr,
    output logic                  out_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_wait
`endif
);

    typedef enum logic [1:0] {StReq, StHold, StDrop} state_t;

    state_t                  state_q;
    logic [ADDR_SIZE-1:0]    pc_q;
    logic [ADDR_SIZE-1:0]    drop_q;
    logic [INSTR_SIZE-1:0]   hold_q;
    logic [ADDR_SIZE-1:0]    pc_inc;

    // Gated by reset so a pending request is abandoned as soon as reset asserts.
    assign imem_req  = reset && (state_q != StHold);
    assign imem_addr = (state_q == StDrop) ? drop_q : pc_q;
    assign pc_inc    = pc_q + ADDR_SIZE'(4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StReq;
            pc_q      <= BOOT_ADDR;
            drop_q    <= '0;
            hold_q    <= NOP_INSTR;
            out_pc    <= '0;
            out_instr <= NOP_INSTR;
            out_valid <= 1'b0;
        end else if (branch_taken) begin
            pc_q      <= branch_target & ~ADDR_SIZE'(3);
            out_instr <= NOP_INSTR;
            out_valid <= 1'b0;
            hold_q    <= NOP_INSTR;
            // An unaccepted request must keep its address until memory answers it.
            if (state_q == StReq && !imem_ready) begin
                drop_q  <= pc_q;
                state_q <= StDrop;
            end else if (state_q != StDrop) begin
                state_q <= StReq;
            end
        end else begin
            unique case (state_q)
                StReq: begin
                    if (imem_ready && stall) begin
                        hold_q  <= imem_data;
                        state_q <= StHold;
                    end else if (imem_ready) begin
                        out_pc    <= pc_q;
                        out_instr <= imem_data;
                        out_valid <= 1'b1;
                        pc_q      <= pc_inc;
                    end else if (!stall) begin
                        out_instr <= NOP_INSTR;
                        out_valid <= 1'b0;
                    end
                end
                StHold: begin
                    if (!stall) begin
                        out_pc    <= pc_q;
                        out_instr <= hold_q;
                        out_valid <= 1'b1;
                        pc_q      <= pc_inc;
                        state_q   <= StReq;
                    end
                end
                StDrop: begin
                    if (imem_ready) begin
                        out_instr <= NOP_INSTR;
                        out_valid <= 1'b0;
                        state_q   <= StReq;
                    end else if (!stall) begin
                        out_instr <= NOP_INSTR;
                        out_valid <= 1'b0;
                    end
                end
                default: state_q <= StReq;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic deliver;

    assign deliver = !branch_taken && !stall &&
                     ((state_q == StReq && imem_ready) || state_q == StHold);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_wait    <= '0;
        end else begin
            if (deliver) perf_fetched <= perf_fetched + 32'd1;
            if (imem_req && !imem_ready) perf_wait <= perf_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_top.sv
// Directed bench for fetch_top: stimulus pushes expected deliveries, a monitor pops and compares.
module tb_fetch_top;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_ready = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_wait;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Memory returns a word tagged with the low half of its address.
    assign imem_data = {16'hC0DE, imem_addr[15:0]};

    fetch_top dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_data     (imem_data),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_valid     (out_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_wait     (perf_wait)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        sb.push_back(e);
    endtask

    // A delivery is a valid IF/ID word loaded on an edge where decode was not stalled.
    initial begin
        logic st;
        exp_t e;
        forever begin
            @(posedge clk);
            st = stall;
            @(negedge clk);
            if (reset && out_valid && !st) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: got out_pc %h expected no delivery", out_pc);
                end else begin
                    e = sb.pop_front();
                    check("sb_pc", out_pc, e.pc);
                    check("sb_instr", out_instr, e.instr);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #2;
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        repeat (2) @(negedge clk);

        // T1: zero-wait memory streams one instruction per cycle.
        reset = 1'b1;
        #1;
        check("t1_req", 32'(imem_req), 32'h1);
        check("t1_addr", imem_addr, 32'h0000_1000);
        check("t1_valid0", 32'(out_valid), 32'h0);
        push(32'h0000_1000, 32'hC0DE_1000);
        @(negedge clk); #1;
        check("t1_valid1", 32'(out_valid), 32'h1);
        push(32'h0000_1004, 32'hC0DE_1004);
        @(negedge clk); #1;
        push(32'h0000_1008, 32'hC0DE_1008);

        // T2: three wait cycles keep the address and produce bubbles.
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        check("t2_addr0", imem_addr, 32'h0000_100C);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check("t2_addr", imem_addr, 32'h0000_100C);
            check("t2_bubble", 32'(out_valid), 32'h0);
            check("t2_nop", out_instr, 32'h0);
        end
        @(negedge clk);
        imem_ready = 1'b1;
        #1;
        check("t2_addr3", imem_addr, 32'h0000_100C);
        check("t2_bubble3", 32'(out_valid), 32'h0);
        push(32'h0000_100C, 32'hC0DE_100C);

        // T3: stall during a transfer parks the word in the hold register.
        @(negedge clk);
        stall = 1'b1;
        #1;
        check("t3_addr", imem_addr, 32'h0000_1010);
        @(negedge clk); #1;
        check("t3_req_hold", 32'(imem_req), 32'h0);
        check("t3_pc_held", out_pc, 32'h0000_100C);
        check("t3_valid_held", 32'(out_valid), 32'h1);
        @(negedge clk);
        stall = 1'b0;
        #1;
        check("t3_req_hold2", 32'(imem_req), 32'h0);
        check("t3_pc_held2", out_pc, 32'h0000_100C);
        push(32'h0000_1010, 32'hC0DE_1010);

        // T4: redirect while a request is pending goes through the drop state.
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        check("t3_next_req", 32'(imem_req), 32'h1);
        check("t3_next_addr", imem_addr, 32'h0000_1014);
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'h0000_2003;
        #1;
        check("t4_addr_pend", imem_addr, 32'h0000_1014);
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        check("t4_drop_req", 32'(imem_req), 32'h1);
        check("t4_drop_addr", imem_addr, 32'h0000_1014);
        check("t4_drop_valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        imem_ready = 1'b1;
        #1;
        check("t4_drop_addr2", imem_addr, 32'h0000_1014);
        @(negedge clk); #1;
        check("t4_discard", 32'(out_valid), 32'h0);
        check("t4_target", imem_addr, 32'h0000_2000);
        push(32'h0000_2000, 32'hC0DE_2000);

        // T5: redirect beats stall while holding.
        @(negedge clk);
        stall = 1'b1;
        #1;
        check("t5_addr", imem_addr, 32'h0000_2004);
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'h0000_3000;
        #1;
        check("t5_req_hold", 32'(imem_req), 32'h0);
        @(negedge clk);
        branch_taken = 1'b0;
        stall        = 1'b0;
        #1;
        check("t5_valid", 32'(out_valid), 32'h0);
        check("t5_nop", out_instr, 32'h0);
        check("t5_req", 32'(imem_req), 32'h1);
        check("t5_addr_tgt", imem_addr, 32'h0000_3000);
        push(32'h0000_3000, 32'hC0DE_3000);

        // T6: PC wrap, then asynchronous reset in the middle of a wait.
        @(negedge clk);
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        check("t6_flush", 32'(out_valid), 32'h0);
        push(32'hFFFF_FFFC, 32'hC0DE_FFFC);
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        check("t6_wrap", imem_addr, 32'h0000_0000);
        check("t6_req", 32'(imem_req), 32'h1);
        check("t6_last_pc", out_pc, 32'hFFFF_FFFC);
        #1;
        reset = 1'b0;
        #1;
        check("t6_arst_req", 32'(imem_req), 32'h0);
        check("t6_arst_valid", 32'(out_valid), 32'h0);
        check("t6_arst_pc", out_pc, 32'h0);
        check("t6_arst_instr", out_instr, 32'h0);
        check("t6_arst_addr", imem_addr, 32'h0000_1000);
        @(negedge clk);
        reset      = 1'b1;
        imem_ready = 1'b1;
        #1;
        check("t6_reboot_addr", imem_addr, 32'h0000_1000);
        push(32'h0000_1000, 32'hC0DE_1000);
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        check("t6_reboot_valid", 32'(out_valid), 32'h1);
        repeat (2) @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
